// File: rtl/usb_bus_event_monitor_if.sv
// UTMI line-state monitor bus: raw PHY inputs in, filtered state and bus events out.
// Remote-wake signals are present only when USB_REMOTE_WAKE_EN is defined.
interface usb_bus_event_monitor_if;
   logic [1:0] line_state;
   logic       tx_active;
   logic [1:0] ls_filt;
   logic       bus_reset;
   logic       reset_start;
   logic       reset_end;
   logic       suspended;
   logic       suspend_start;
   logic       resuming;
   logic       resume_done;
`ifdef USB_REMOTE_WAKE_EN
   logic       remote_wake_req;
   logic       drive_k;

   modport master (
      input  line_state, tx_active, remote_wake_req,
      output ls_filt, bus_reset, reset_start, reset_end,
             suspended, suspend_start, resuming, resume_done, drive_k
   );
   modport slave (
      output line_state, tx_active, remote_wake_req,
      input  ls_filt, bus_reset, reset_start, reset_end,
             suspended, suspend_start, resuming, resume_done, drive_k
   );
`else
   modport master (
      input  line_state, tx_active,
      output ls_filt, bus_reset, reset_start, reset_end,
             suspended, suspend_start, resuming, resume_done
   );
   modport slave (
      output line_state, tx_active,
      input  ls_filt, bus_reset, reset_start, reset_end,
             suspended, suspend_start, resuming, resume_done
   );
`endif
endinterface

// File: rtl/usb_bus_event_monitor.sv
// Glitch-filters the UTMI line state and tracks bus reset, suspend and resume events.
// Define USB_REMOTE_WAKE_EN to compile in the remote-wake K driver (WAKE_DRIVE state).
module usb_bus_event_monitor #(
   parameter int FILTER_CYCLES   = 2,
   parameter int RESET_CYCLES    = 150,
   parameter int SUSPEND_CYCLES  = 180000,
   parameter int WAKE_MIN_CYCLES = 120000,
   parameter int WAKE_K_CYCLES   = 120000,
   parameter int CNT_W           = 24
) (
   input logic                      clk,
   input logic                      rst_n,
   usb_bus_event_monitor_if.master  bus
);

   localparam int RUN_W = $clog2(FILTER_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(FILTER_CYCLES);
   localparam logic [CNT_W-1:0] RESET_LIM   = CNT_W'(RESET_CYCLES);
   localparam logic [CNT_W-1:0] SUSPEND_LIM = CNT_W'(SUSPEND_CYCLES);
   localparam longint unsigned  CNT_MAX     = (64'd1 << CNT_W) - 64'd1;

   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_J   = 2'b01;
   localparam logic [1:0] LS_K   = 2'b10;

   if (FILTER_CYCLES < 1 || WAKE_K_CYCLES < 1 ||
       64'(RESET_CYCLES) > CNT_MAX || 64'(SUSPEND_CYCLES) > CNT_MAX ||
       64'(WAKE_MIN_CYCLES) > CNT_MAX || 64'(WAKE_K_CYCLES) > CNT_MAX) begin : g_bad_cfg
      $error("usb_bus_event_monitor: invalid parameter set");
   end

   typedef enum logic [2:0] {
      ST_ACTIVE,
      ST_IN_RESET,
      ST_SUSPENDED,
      ST_RESUMING
`ifdef USB_REMOTE_WAKE_EN
      , ST_WAKE_DRIVE
`endif
   } state_t;

   state_t state_reg, state_next;

   logic [1:0]       cand_reg, cand_next;
   logic [RUN_W-1:0] run_reg, run_next;
   logic [1:0]       ls_filt_reg, ls_filt_next;

   logic reset_start_reg, reset_start_next;
   logic reset_end_reg, reset_end_next;
   logic suspend_start_reg, suspend_start_next;
   logic resume_done_reg, resume_done_next;

   logic [2:0]            cnt_inc;
   logic                  cnt_clr;
   logic [2:0][CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0]      se0_cnt;
   logic [CNT_W-1:0]      idle_cnt;
   logic [CNT_W-1:0]      sus_cnt;

   // Filter: a raw value must be seen on FILTER_CYCLES consecutive edges to pass through.
   always_comb begin
      cand_next    = bus.line_state;
      run_next     = run_reg;
      ls_filt_next = ls_filt_reg;
      if (bus.line_state != cand_reg) begin
         run_next = RUN_W'(1);
      end else if (run_reg != RUN_MAX) begin
         run_next = run_reg + 1'b1;
      end
      if (run_next == RUN_MAX) begin
         ls_filt_next = bus.line_state;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_reg    <= LS_J;
         run_reg     <= '0;
         ls_filt_reg <= LS_J;
      end else begin
         cand_reg    <= cand_next;
         run_reg     <= run_next;
         ls_filt_reg <= ls_filt_next;
      end
   end

   // Event counters: 0 = SE0 run, 1 = idle J run, 2 = time in SUSPENDED / WAKE_DRIVE.
   always_comb begin
      cnt_inc[0] = (ls_filt_reg == LS_SE0);
      cnt_inc[1] = (ls_filt_reg == LS_J) && !bus.tx_active;
      cnt_inc[2] = (state_reg == ST_SUSPENDED);
`ifdef USB_REMOTE_WAKE_EN
      if (state_reg == ST_WAKE_DRIVE) begin
         cnt_inc[2] = 1'b1;
      end
`endif
      cnt_clr = (state_next != state_reg);
   end

   genvar gi;
   for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (!rst_n || cnt_clr || !cnt_inc[gi]) begin
            cnt_reg <= '0;
         end else if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
      assign cnt_q[gi] = cnt_reg;
   end

   assign se0_cnt  = cnt_q[0];
   assign idle_cnt = cnt_q[1];
   assign sus_cnt  = cnt_q[2];

`ifdef USB_REMOTE_WAKE_EN
   localparam logic [CNT_W-1:0] WAKE_MIN_LIM = CNT_W'(WAKE_MIN_CYCLES);
   localparam logic [CNT_W-1:0] WAKE_K_LAST  = CNT_W'(WAKE_K_CYCLES - 1);
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_ACTIVE: begin
            if (se0_cnt >= RESET_LIM) begin
               state_next = ST_IN_RESET;
            end else if (idle_cnt >= SUSPEND_LIM) begin
               state_next = ST_SUSPENDED;
            end
         end
         ST_IN_RESET: begin
            if (ls_filt_reg != LS_SE0) begin
               state_next = ST_ACTIVE;
            end
         end
         ST_SUSPENDED: begin
            // Host K wins over a local wake request, which wins over reset timing.
            if (ls_filt_reg == LS_K) begin
               state_next = ST_RESUMING;
            end
`ifdef USB_REMOTE_WAKE_EN
            else if (bus.remote_wake_req && (sus_cnt >= WAKE_MIN_LIM)) begin
               state_next = ST_WAKE_DRIVE;
            end
`endif
            else if (se0_cnt >= RESET_LIM) begin
               state_next = ST_IN_RESET;
            end
         end
         ST_RESUMING: begin
            if (ls_filt_reg != LS_K) begin
               state_next = ST_ACTIVE;
            end
         end
`ifdef USB_REMOTE_WAKE_EN
         ST_WAKE_DRIVE: begin
            // Our own K is on the line, so only the timer decides the exit.
            if (sus_cnt >= WAKE_K_LAST) begin
               state_next = ST_RESUMING;
            end
         end
`endif
         default: state_next = ST_ACTIVE;
      endcase

      reset_start_next   = (state_next == ST_IN_RESET) && (state_reg != ST_IN_RESET);
      reset_end_next     = (state_reg == ST_IN_RESET) && (state_next != ST_IN_RESET);
      suspend_start_next = (state_next == ST_SUSPENDED) && (state_reg != ST_SUSPENDED);
      resume_done_next   = (state_reg == ST_RESUMING) && (state_next == ST_ACTIVE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg         <= ST_ACTIVE;
         reset_start_reg   <= 1'b0;
         reset_end_reg     <= 1'b0;
         suspend_start_reg <= 1'b0;
         resume_done_reg   <= 1'b0;
      end else begin
         state_reg         <= state_next;
         reset_start_reg   <= reset_start_next;
         reset_end_reg     <= reset_end_next;
         suspend_start_reg <= suspend_start_next;
         resume_done_reg   <= resume_done_next;
      end
   end

   assign bus.ls_filt       = ls_filt_reg;
   assign bus.bus_reset     = (state_reg == ST_IN_RESET);
   assign bus.reset_start   = reset_start_reg;
   assign bus.reset_end     = reset_end_reg;
   assign bus.suspend_start = suspend_start_reg;
   assign bus.resuming      = (state_reg == ST_RESUMING);
   assign bus.resume_done   = resume_done_reg;
`ifdef USB_REMOTE_WAKE_EN
   assign bus.suspended     = (state_reg == ST_SUSPENDED) || (state_reg == ST_RESUMING) ||
                              (state_reg == ST_WAKE_DRIVE);
   assign bus.drive_k       = (state_reg == ST_WAKE_DRIVE);
`else
   assign bus.suspended     = (state_reg == ST_SUSPENDED) || (state_reg == ST_RESUMING);
`endif

endmodule

// File: tb/tb_usb_bus_event_monitor.sv
// Directed bench for usb_bus_event_monitor; edge numbers are counted from reset release.
// Remote-wake scenarios are exercised only when USB_REMOTE_WAKE_EN is defined.
module tb_usb_bus_event_monitor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   usb_bus_event_monitor_if bus_if ();

   usb_bus_event_monitor #(
      .FILTER_CYCLES   (2),
      .RESET_CYCLES    (150),
      .SUSPEND_CYCLES  (1000),
      .WAKE_MIN_CYCLES (200),
      .WAKE_K_CYCLES   (100),
      .CNT_W           (24)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus_if.line_state = 2'b01;
      bus_if.tx_active  = 1'b0;
`ifdef USB_REMOTE_WAKE_EN
      bus_if.remote_wake_req = 1'b0;
`endif
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Idle J from reset: idle count hits 1000 at edge 1000, SUSPENDED after edge 1001.
   task automatic enter_suspend();
      do_reset();
      repeat (1001) tick();
   endtask

   task automatic test_reset();
      logic [8:0] outs;
      rst_n = 1'b0;
      bus_if.line_state = 2'b10;
      bus_if.tx_active  = 1'b1;
`ifdef USB_REMOTE_WAKE_EN
      bus_if.remote_wake_req = 1'b1;
`endif
      tick();
      tick();
      outs = {bus_if.ls_filt, bus_if.bus_reset, bus_if.reset_start, bus_if.reset_end,
              bus_if.suspended, bus_if.suspend_start, bus_if.resuming, bus_if.resume_done};
      checks++;
      if (outs !== 9'b01_0000000) begin
         fails++;
         $display("FAIL reset_outputs: got %b expected %b", outs, 9'b01_0000000);
      end
      checks++;
      if (u_dut.se0_cnt !== 24'd0) begin
         fails++;
         $display("FAIL reset_se0_cnt: got %0d expected 0", u_dut.se0_cnt);
      end
`ifdef USB_REMOTE_WAKE_EN
      checks++;
      if (bus_if.drive_k !== 1'b0) begin
         fails++;
         $display("FAIL reset_drive_k: got %b expected 0", bus_if.drive_k);
      end
`endif
      $display("test_reset: outputs %b", outs);
   endtask

   task automatic test_bus_reset();
      int rs_edge = -1, rs_cnt = 0, br_cnt = 0, re_edge = -1, re_cnt = 0;
      do_reset();
      bus_if.line_state = 2'b00;
      for (int e = 1; e <= 310; e++) begin
         if (e == 301) bus_if.line_state = 2'b01;
         tick();
         if (bus_if.reset_start === 1'b1) begin
            rs_cnt++;
            if (rs_edge < 0) rs_edge = e;
         end
         if (bus_if.bus_reset === 1'b1) br_cnt++;
         if (bus_if.reset_end === 1'b1) begin
            re_cnt++;
            if (re_edge < 0) re_edge = e;
         end
      end
      checks++;
      if (rs_edge != 153) begin
         fails++;
         $display("FAIL bus_reset_start_edge: got %0d expected 153", rs_edge);
      end
      checks++;
      if (rs_cnt != 1) begin
         fails++;
         $display("FAIL bus_reset_start_count: got %0d expected 1", rs_cnt);
      end
      checks++;
      if (br_cnt != 150) begin
         fails++;
         $display("FAIL bus_reset_level_cycles: got %0d expected 150", br_cnt);
      end
      checks++;
      if (re_edge != 303 || re_cnt != 1) begin
         fails++;
         $display("FAIL bus_reset_end: got edge %0d count %0d expected edge 303 count 1",
                  re_edge, re_cnt);
      end
      $display("test_bus_reset: reset_start@%0d reset_end@%0d", rs_edge, re_edge);
   endtask

   task automatic test_reset_boundary();
      int rs_cnt = 0;
      logic [23:0] cnt_151 = '0;
      do_reset();
      bus_if.line_state = 2'b00;
      for (int e = 1; e <= 200; e++) begin
         if (e == 150) bus_if.line_state = 2'b01;
         tick();
         if (e == 151) cnt_151 = u_dut.se0_cnt;
         if (bus_if.reset_start === 1'b1 || bus_if.bus_reset === 1'b1) rs_cnt++;
      end
      checks++;
      if (cnt_151 !== 24'd149) begin
         fails++;
         $display("FAIL short_se0_peak_cnt: got %0d expected 149", cnt_151);
      end
      checks++;
      if (rs_cnt != 0) begin
         fails++;
         $display("FAIL short_se0_no_reset: got %0d reset cycles expected 0", rs_cnt);
      end
      checks++;
      if (u_dut.se0_cnt !== 24'd0) begin
         fails++;
         $display("FAIL short_se0_cnt_cleared: got %0d expected 0", u_dut.se0_cnt);
      end
      $display("test_reset_boundary: se0_cnt peak %0d", cnt_151);
   endtask

   task automatic test_reset_abort();
      int re_cnt = 0;
      do_reset();
      bus_if.line_state = 2'b00;
      repeat (200) tick();
      checks++;
      if (bus_if.bus_reset !== 1'b1) begin
         fails++;
         $display("FAIL abort_in_reset: got %b expected 1", bus_if.bus_reset);
      end
      rst_n = 1'b0;
      tick();
      if (bus_if.reset_end === 1'b1) re_cnt++;
      checks++;
      if (bus_if.bus_reset !== 1'b0 || bus_if.ls_filt !== 2'b01) begin
         fails++;
         $display("FAIL abort_cleared: got bus_reset %b ls_filt %b expected 0 01",
                  bus_if.bus_reset, bus_if.ls_filt);
      end
      rst_n = 1'b1;
      bus_if.line_state = 2'b01;
      for (int e = 0; e < 5; e++) begin
         tick();
         if (bus_if.reset_end === 1'b1) re_cnt++;
      end
      checks++;
      if (re_cnt != 0) begin
         fails++;
         $display("FAIL abort_no_end_pulse: got %0d pulses expected 0", re_cnt);
      end
      $display("test_reset_abort: reset_end pulses %0d", re_cnt);
   endtask

   task automatic test_suspend();
      int ss_edge = -1, ss_cnt = 0;
      logic sus_1510 = 1'bx, sus_1511 = 1'bx;
      do_reset();
      for (int e = 1; e <= 1520; e++) begin
         bus_if.tx_active = (e >= 500 && e <= 510);
         tick();
         if (bus_if.suspend_start === 1'b1) begin
            ss_cnt++;
            if (ss_edge < 0) ss_edge = e;
         end
         if (e == 1510) sus_1510 = bus_if.suspended;
         if (e == 1511) sus_1511 = bus_if.suspended;
      end
      checks++;
      if (ss_edge != 1511 || ss_cnt != 1) begin
         fails++;
         $display("FAIL suspend_start: got edge %0d count %0d expected edge 1511 count 1",
                  ss_edge, ss_cnt);
      end
      checks++;
      if (sus_1510 !== 1'b0 || sus_1511 !== 1'b1) begin
         fails++;
         $display("FAIL suspend_level: got %b%b expected 01", sus_1510, sus_1511);
      end
      $display("test_suspend: suspend_start@%0d", ss_edge);
   endtask

   task automatic test_resume();
      int rsm_edge = -1, rd_edge = -1, rd_cnt = 0, rs_cnt = 0;
      logic [1:0] filt_2 = 2'bxx;
      logic sus_1002 = 1'bx, sus_1003 = 1'bx, rsm_1003 = 1'bx;
      enter_suspend();
      checks++;
      if (bus_if.suspended !== 1'b1) begin
         fails++;
         $display("FAIL resume_setup_suspended: got %b expected 1", bus_if.suspended);
      end
      for (int e = 1; e <= 1010; e++) begin
         bus_if.line_state = (e <= 1000) ? 2'b10 : ((e <= 1002) ? 2'b00 : 2'b01);
         tick();
         if (e == 2) filt_2 = bus_if.ls_filt;
         if (bus_if.resuming === 1'b1 && rsm_edge < 0) rsm_edge = e;
         if (bus_if.resume_done === 1'b1) begin
            rd_cnt++;
            if (rd_edge < 0) rd_edge = e;
         end
         if (bus_if.reset_start === 1'b1) rs_cnt++;
         if (e == 1002) sus_1002 = bus_if.suspended;
         if (e == 1003) begin
            sus_1003 = bus_if.suspended;
            rsm_1003 = bus_if.resuming;
         end
      end
      checks++;
      if (filt_2 !== 2'b10 || rsm_edge != 3) begin
         fails++;
         $display("FAIL resume_start: got ls_filt %b resuming@%0d expected 10 @3", filt_2, rsm_edge);
      end
      checks++;
      if (rd_edge != 1003 || rd_cnt != 1) begin
         fails++;
         $display("FAIL resume_done: got edge %0d count %0d expected edge 1003 count 1",
                  rd_edge, rd_cnt);
      end
      checks++;
      if ({sus_1002, sus_1003, rsm_1003} !== 3'b100) begin
         fails++;
         $display("FAIL resume_levels: got %b%b%b expected 100", sus_1002, sus_1003, rsm_1003);
      end
      checks++;
      if (rs_cnt != 0) begin
         fails++;
         $display("FAIL resume_eop_not_reset: got %0d reset_start expected 0", rs_cnt);
      end
      $display("test_resume: resuming@%0d resume_done@%0d", rsm_edge, rd_edge);
   endtask

   task automatic test_glitch();
      int bad_filt = 0, rsm_cnt = 0;
      enter_suspend();
      for (int e = 1; e <= 20; e++) begin
         bus_if.line_state = (e == 1) ? 2'b10 : 2'b01;
         tick();
         if (bus_if.ls_filt !== 2'b01) bad_filt++;
         if (bus_if.resuming === 1'b1) rsm_cnt++;
      end
      checks++;
      if (bad_filt != 0) begin
         fails++;
         $display("FAIL glitch_filtered: got %0d non-J cycles expected 0", bad_filt);
      end
      checks++;
      if (rsm_cnt != 0 || bus_if.suspended !== 1'b1) begin
         fails++;
         $display("FAIL glitch_state: got resuming %0d suspended %b expected 0 1",
                  rsm_cnt, bus_if.suspended);
      end
      $display("test_glitch: non-J filtered cycles %0d", bad_filt);
   endtask

   task automatic test_suspend_reset();
      int rs_edge = -1;
      logic sus_152 = 1'bx, sus_153 = 1'bx, br_153 = 1'bx;
      enter_suspend();
      bus_if.line_state = 2'b00;
      for (int e = 1; e <= 160; e++) begin
         tick();
         if (bus_if.reset_start === 1'b1 && rs_edge < 0) rs_edge = e;
         if (e == 152) sus_152 = bus_if.suspended;
         if (e == 153) begin
            sus_153 = bus_if.suspended;
            br_153  = bus_if.bus_reset;
         end
      end
      checks++;
      if (rs_edge != 153) begin
         fails++;
         $display("FAIL suspend_reset_start: got %0d expected 153", rs_edge);
      end
      checks++;
      if ({sus_152, sus_153, br_153} !== 3'b101) begin
         fails++;
         $display("FAIL suspend_reset_levels: got %b%b%b expected 101", sus_152, sus_153, br_153);
      end
      $display("test_suspend_reset: reset_start@%0d", rs_edge);
   endtask

`ifdef USB_REMOTE_WAKE_EN
   task automatic test_remote_wake();
      int dk_edge = -1, dk_cnt = 0, rsm_edge = -1, rd_edge = -1;
      enter_suspend();
      for (int e = 1; e <= 420; e++) begin
         bus_if.remote_wake_req = (e == 101) || (e == 251);
         bus_if.line_state = (e >= 251 && e <= 400) ? 2'b10 : 2'b01;
         tick();
         if (bus_if.drive_k === 1'b1) begin
            dk_cnt++;
            if (dk_edge < 0) dk_edge = e;
         end
         if (bus_if.resuming === 1'b1 && rsm_edge < 0) rsm_edge = e;
         if (bus_if.resume_done === 1'b1 && rd_edge < 0) rd_edge = e;
      end
      bus_if.remote_wake_req = 1'b0;
      checks++;
      if (dk_edge != 251) begin
         fails++;
         $display("FAIL wake_drive_start: got %0d expected 251", dk_edge);
      end
      checks++;
      if (dk_cnt != 100) begin
         fails++;
         $display("FAIL wake_drive_length: got %0d expected 100", dk_cnt);
      end
      checks++;
      if (rsm_edge != 351 || rd_edge != 403) begin
         fails++;
         $display("FAIL wake_resume: got resuming@%0d done@%0d expected 351 403", rsm_edge, rd_edge);
      end
      $display("test_remote_wake: drive_k@%0d for %0d cycles", dk_edge, dk_cnt);

      enter_suspend();
      bus_if.remote_wake_req = 1'b1;
      repeat (220) tick();
      checks++;
      if (bus_if.drive_k !== 1'b1) begin
         fails++;
         $display("FAIL wake_abort_setup: got %b expected 1", bus_if.drive_k);
      end
      rst_n = 1'b0;
      bus_if.remote_wake_req = 1'b0;
      tick();
      checks++;
      if (bus_if.drive_k !== 1'b0 || bus_if.suspended !== 1'b0) begin
         fails++;
         $display("FAIL wake_abort: got drive_k %b suspended %b expected 0 0",
                  bus_if.drive_k, bus_if.suspended);
      end
      rst_n = 1'b1;
      $display("test_remote_wake: drive aborted by reset");
   endtask
`endif

   initial begin
      test_reset();
      test_bus_reset();
      test_reset_boundary();
      test_reset_abort();
      test_suspend();
      test_resume();
      test_glitch();
      test_suspend_reset();
`ifdef USB_REMOTE_WAKE_EN
      test_remote_wake();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
